rc_sram_ctrl: RTL and testbench
===============================

# rc_sram_ctrl

SRAM access controller directly downstream of the issue stage (ISU). Accepts one dequeued request at a time on the d_rc handshake and sequences the data-SRAM access: read for loads, byte-masked write from the write buffer for stores, and full-line write of memory-controller refill data for refill ops. Returns one response per load or store to the requesting xbar channel and frees write-buffer entries once their data is committed.

## Interface
- Cfg, '0: mpc_cfg_t design configuration; supplies setWidth and nlineWidth.
- setWidth_t, logic: set index type.
- wayIndexWidth_t, logic: way index type.
- wbufWidth_t, logic: write-buffer entry id type.
- robWidth_t, logic: ROB id type.
- nlineWidth_t, logic: SRAM line address type, {way, set}.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- d_rc_valid  in  1  request valid.
- d_rc_ready  out  1  request accepted when valid&ready.
- d_rc_channel_1hot_id  in  3  requesting channel, one-hot.
- d_rc_rob_id  in  robWidth_t  ROB id.
- d_rc_op  in  3  cache op (LOAD, STORE, LOAD_REFILL, STORE_REFILL).
- d_rc_set / d_rc_way  in  setWidth_t / wayIndexWidth_t  target line.
- d_rc_wbuf_id  in  wbufWidth_t  write-buffer entry for stores.
- d_rc_refill_data  in  128  refill line for *_REFILL ops.
- wbuf_rd_valid / wbuf_rd_id  out  1 / wbufWidth_t  write-buffer read request.
- wbuf_rd_data / wbuf_rd_be  in  128 / 16  write data and byte enables, returned 1 cycle after wbuf_rd_valid.
- wbuf_free_valid / wbuf_free_id  out  1 / wbufWidth_t  entry release pulse.
- sram_ce / sram_we  out  1 / 1  SRAM enable, write enable.
- sram_addr  out  nlineWidth_t  {way, set}.
- sram_wdata / sram_be  out  128 / 16  write data, byte enables.
- sram_rdata  in  128  read data, valid 1 cycle after a read enable.
- resp_valid / resp_ready  out / in  1 / 1  response handshake.
- resp_channel_1hot_id / resp_rob_id / resp_op / resp_data  out  3 / robWidth_t / 3 / 128  response payload.
- illegal_op  out  1  sticky flag: an unsupported op was accepted.

## Operation
- States: IDLE, SRAM_RD, RD_CAP, WBUF_RD, SRAM_WR, RESP. d_rc_ready = (state==IDLE); it never depends on d_rc_valid. On accept, all request fields including refill data are registered.
- LOAD: IDLE -> SRAM_RD (sram_ce=1, we=0) -> RD_CAP (sram_rdata captured into resp_data) -> RESP.
- STORE: IDLE -> WBUF_RD (wbuf_rd_valid=1) -> SRAM_WR (ce=we=1, wdata=wbuf_rd_data, be=wbuf_rd_be, wbuf_free pulse) -> RESP with resp_data=0.
- STORE_REFILL: same path as STORE, but in SRAM_WR per byte i: wdata[i] = be[i] ? wbuf byte : refill byte, and sram_be=16'hFFFF.
- LOAD_REFILL: IDLE -> SRAM_WR (full-line refill write, be=16'hFFFF) -> RESP with resp_data = refill data. No SRAM read.
- Other op codes: accepted, no SRAM, wbuf or response activity, illegal_op set; state stays IDLE.
- RESP: resp_op = registered op; payload is held stable while resp_valid=1 and resp_ready=0. Handshake -> IDLE.
- sram_addr = {way, set} from the registered request, driven in SRAM_RD and SRAM_WR. sram_ce=0 in every other state.

## Timing
- Accept at cycle T. resp_valid first asserts at T+3 (LOAD), T+3 (STORE, STORE_REFILL), T+2 (LOAD_REFILL).
- Next accept is at the earliest 1 cycle after the resp handshake. No overlap between requests.
- wbuf_free pulses exactly 1 cycle, in the same cycle as the SRAM write. The SRAM write is never issued without its wbuf data.
- Reset (asynchronous, any state) forces IDLE. All outputs are 0 except d_rc_ready=1 once IDLE. illegal_op clears. An in-flight request is dropped and its wbuf entry is not freed; upstream is reset with this block.
- resp_ready held low indefinitely: the block stalls in RESP and d_rc_ready stays 0.

## Structure
- mpc_types: CACHE_OP_* encodings (existing), rc_state_e enum, RC_LINE_BYTES=16.
- Sub-module rc_byte_merge: combinational 128-bit byte-mask merge (wbuf over refill), used in SRAM_WR.

## Test plan
- LOAD set=3, way=1, sram_rdata=128'hA5.. at T+2 -> sram_addr={1,3} read at T+1; resp_valid at T+3, resp_data=128'hA5.., rob id echoed.
- STORE wbuf_id=5, wbuf_rd_be=16'h000F -> wbuf_rd_id=5 at T+1; write with be=16'h000F and wbuf_free_id=5 at T+2; resp at T+3 with data 0.
- STORE_REFILL refill=all 16'h11 bytes, wbuf bytes 0x22, be=16'h8001 -> written line has bytes 0 and 15 = 0x22, all others 0x11, be=16'hFFFF.
- LOAD_REFILL refill=128'hDEAD.. -> full write at T+1, resp_data=128'hDEAD.. at T+2, no sram_we=0 read occurs.
- Hold resp_ready=0 for 10 cycles with d_rc_valid=1 -> payload stable, d_rc_ready=0 throughout; accept occurs 1 cycle after the handshake.
- Assert rst in SRAM_WR and issue op=3'b111 after reset -> outputs 0 and IDLE; after the bad op, illegal_op=1 and no SRAM or response activity.

Source files
------------

// File: rtl/rc_sram_ctrl_pkg.sv
// Shared types and constants for the ISU-side data-SRAM access controller.
package rc_sram_ctrl_pkg;

  typedef struct packed {
    int unsigned setWidth;
    int unsigned wayIndexWidth;
    int unsigned wbufWidth;
    int unsigned robWidth;
  } mpc_cfg_t;

  localparam mpc_cfg_t DEFAULT_CFG = '{setWidth: 6, wayIndexWidth: 2, wbufWidth: 3, robWidth: 5};

  localparam logic [2:0] CACHE_OP_LOAD         = 3'd0;
  localparam logic [2:0] CACHE_OP_STORE        = 3'd1;
  localparam logic [2:0] CACHE_OP_LOAD_REFILL  = 3'd2;
  localparam logic [2:0] CACHE_OP_STORE_REFILL = 3'd3;

  localparam logic [2:0] RC_IDLE    = 3'd0;
  localparam logic [2:0] RC_SRAM_RD = 3'd1;
  localparam logic [2:0] RC_RD_CAP  = 3'd2;
  localparam logic [2:0] RC_WBUF_RD = 3'd3;
  localparam logic [2:0] RC_SRAM_WR = 3'd4;
  localparam logic [2:0] RC_RESP    = 3'd5;

  localparam int unsigned RC_LINE_BYTES = 16;
  localparam int unsigned RC_LINE_BITS  = RC_LINE_BYTES * 8;

  function automatic logic cache_op_legal(input logic [2:0] op);
    return (op == CACHE_OP_LOAD) || (op == CACHE_OP_STORE) ||
           (op == CACHE_OP_LOAD_REFILL) || (op == CACHE_OP_STORE_REFILL);
  endfunction

endpackage

// File: rtl/rc_sram_ctrl_if.sv
// Request (d_rc) and response handshakes between the issue stage and the SRAM controller.
interface rc_sram_ctrl_if
  import rc_sram_ctrl_pkg::*;
#(
  parameter mpc_cfg_t Cfg = DEFAULT_CFG
) ();

  logic                         d_rc_valid;
  logic                         d_rc_ready;
  logic [2:0]                   d_rc_channel_1hot_id;
  logic [Cfg.robWidth-1:0]      d_rc_rob_id;
  logic [2:0]                   d_rc_op;
  logic [Cfg.setWidth-1:0]      d_rc_set;
  logic [Cfg.wayIndexWidth-1:0] d_rc_way;
  logic [Cfg.wbufWidth-1:0]     d_rc_wbuf_id;
  logic [RC_LINE_BITS-1:0]      d_rc_refill_data;

  logic                         resp_valid;
  logic                         resp_ready;
  logic [2:0]                   resp_channel_1hot_id;
  logic [Cfg.robWidth-1:0]      resp_rob_id;
  logic [2:0]                   resp_op;
  logic [RC_LINE_BITS-1:0]      resp_data;

  modport master (
    output d_rc_valid, d_rc_channel_1hot_id, d_rc_rob_id, d_rc_op, d_rc_set, d_rc_way,
           d_rc_wbuf_id, d_rc_refill_data, resp_ready,
    input  d_rc_ready, resp_valid, resp_channel_1hot_id, resp_rob_id, resp_op, resp_data
  );

  modport slave (
    input  d_rc_valid, d_rc_channel_1hot_id, d_rc_rob_id, d_rc_op, d_rc_set, d_rc_way,
           d_rc_wbuf_id, d_rc_refill_data, resp_ready,
    output d_rc_ready, resp_valid, resp_channel_1hot_id, resp_rob_id, resp_op, resp_data
  );

endinterface

// File: rtl/rc_sram_ctrl_byte_merge.sv
// Byte-masked line merge: write-buffer bytes override refill bytes where be is set.
module rc_byte_merge
  import rc_sram_ctrl_pkg::*;
(
  input  logic [RC_LINE_BITS-1:0]  wbuf_data,
  input  logic [RC_LINE_BYTES-1:0] be,
  input  logic [RC_LINE_BITS-1:0]  refill_data,
  output logic [RC_LINE_BITS-1:0]  merged
);

  always_comb begin
    merged = refill_data;
    for (int unsigned i = 0; i < RC_LINE_BYTES; i++) begin
      if (be[i]) merged[i*8 +: 8] = wbuf_data[i*8 +: 8];
    end
  end

endmodule

// File: rtl/rc_sram_ctrl.sv
// Data-SRAM access sequencer: one request at a time for loads, stores and line refills.
module rc_sram_ctrl
  import rc_sram_ctrl_pkg::*;
#(
  parameter mpc_cfg_t Cfg = DEFAULT_CFG
) (
  input  logic                                          clk,
  input  logic                                          rst,
  rc_sram_ctrl_if.slave                                 bus,
  output logic                                          wbuf_rd_valid,
  output logic [Cfg.wbufWidth-1:0]                      wbuf_rd_id,
  input  logic [RC_LINE_BITS-1:0]                       wbuf_rd_data,
  input  logic [RC_LINE_BYTES-1:0]                      wbuf_rd_be,
  output logic                                          wbuf_free_valid,
  output logic [Cfg.wbufWidth-1:0]                      wbuf_free_id,
  output logic                                          sram_ce,
  output logic                                          sram_we,
  output logic [Cfg.wayIndexWidth+Cfg.setWidth-1:0]     sram_addr,
  output logic [RC_LINE_BITS-1:0]                       sram_wdata,
  output logic [RC_LINE_BYTES-1:0]                      sram_be,
  input  logic [RC_LINE_BITS-1:0]                       sram_rdata,
  output logic                                          illegal_op
);

  logic [2:0]                   state, state_nxt;
  logic [2:0]                   op_q, chan_q;
  logic [Cfg.robWidth-1:0]      rob_q;
  logic [Cfg.setWidth-1:0]      set_q;
  logic [Cfg.wayIndexWidth-1:0] way_q;
  logic [Cfg.wbufWidth-1:0]     wbuf_q;
  logic [RC_LINE_BITS-1:0]      refill_q, resp_data_q, merged;
  logic                         illegal_q, accept, op_is_store;

  assign accept      = bus.d_rc_valid && (state == RC_IDLE);
  assign op_is_store = (op_q == CACHE_OP_STORE) || (op_q == CACHE_OP_STORE_REFILL);

  rc_byte_merge u_merge (
    .wbuf_data   (wbuf_rd_data),
    .be          (wbuf_rd_be),
    .refill_data (refill_q),
    .merged      (merged)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      RC_IDLE: begin
        if (accept) begin
          case (bus.d_rc_op)
            CACHE_OP_LOAD:         state_nxt = RC_SRAM_RD;
            CACHE_OP_STORE,
            CACHE_OP_STORE_REFILL: state_nxt = RC_WBUF_RD;
            CACHE_OP_LOAD_REFILL:  state_nxt = RC_SRAM_WR;
            default:               state_nxt = RC_IDLE;
          endcase
        end
      end
      RC_SRAM_RD: state_nxt = RC_RD_CAP;
      RC_RD_CAP:  state_nxt = RC_RESP;
      RC_WBUF_RD: state_nxt = RC_SRAM_WR;
      RC_SRAM_WR: state_nxt = RC_RESP;
      RC_RESP:    if (bus.resp_ready) state_nxt = RC_IDLE;
      default:    state_nxt = RC_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RC_IDLE;
      op_q        <= '0;
      chan_q      <= '0;
      rob_q       <= '0;
      set_q       <= '0;
      way_q       <= '0;
      wbuf_q      <= '0;
      refill_q    <= '0;
      resp_data_q <= '0;
      illegal_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q     <= bus.d_rc_op;
        chan_q   <= bus.d_rc_channel_1hot_id;
        rob_q    <= bus.d_rc_rob_id;
        set_q    <= bus.d_rc_set;
        way_q    <= bus.d_rc_way;
        wbuf_q   <= bus.d_rc_wbuf_id;
        refill_q <= bus.d_rc_refill_data;
        if (!cache_op_legal(bus.d_rc_op)) illegal_q <= 1'b1;
      end
      if (state == RC_RD_CAP) resp_data_q <= sram_rdata;
      if (state == RC_SRAM_WR) resp_data_q <= (op_q == CACHE_OP_LOAD_REFILL) ? refill_q : '0;
    end
  end

  // Write data comes straight from the wbuf return path in SRAM_WR so the write never precedes its data.
  always_comb begin
    sram_ce         = 1'b0;
    sram_we         = 1'b0;
    sram_addr       = '0;
    sram_wdata      = '0;
    sram_be         = '0;
    wbuf_free_valid = 1'b0;
    wbuf_free_id    = '0;
    if (state == RC_SRAM_RD) begin
      sram_ce   = 1'b1;
      sram_addr = {way_q, set_q};
    end
    if (state == RC_SRAM_WR) begin
      sram_ce   = 1'b1;
      sram_we   = 1'b1;
      sram_addr = {way_q, set_q};
      sram_be   = '1;
      case (op_q)
        CACHE_OP_STORE: begin
          sram_wdata = wbuf_rd_data;
          sram_be    = wbuf_rd_be;
        end
        CACHE_OP_STORE_REFILL: sram_wdata = merged;
        default:               sram_wdata = refill_q;
      endcase
      if (op_is_store) begin
        wbuf_free_valid = 1'b1;
        wbuf_free_id    = wbuf_q;
      end
    end
  end

  assign wbuf_rd_valid            = (state == RC_WBUF_RD);
  assign wbuf_rd_id               = (state == RC_WBUF_RD) ? wbuf_q : '0;
  assign bus.d_rc_ready           = (state == RC_IDLE);
  assign bus.resp_valid           = (state == RC_RESP);
  assign bus.resp_channel_1hot_id = chan_q;
  assign bus.resp_rob_id          = rob_q;
  assign bus.resp_op              = op_q;
  assign bus.resp_data            = resp_data_q;
  assign illegal_op               = illegal_q;

endmodule

// File: tb/tb_rc_sram_ctrl.sv
// Directed bench for rc_sram_ctrl with a response scoreboard decoupled from stimulus.
module tb_rc_sram_ctrl;
  import rc_sram_ctrl_pkg::*;

  localparam mpc_cfg_t CFG = DEFAULT_CFG;

  logic         clk = 1'b0;
  logic         rst;
  logic         wbuf_rd_valid;
  logic [2:0]   wbuf_rd_id;
  logic [127:0] wbuf_rd_data;
  logic [15:0]  wbuf_rd_be;
  logic         wbuf_free_valid;
  logic [2:0]   wbuf_free_id;
  logic         sram_ce, sram_we;
  logic [7:0]   sram_addr;
  logic [127:0] sram_wdata;
  logic [15:0]  sram_be;
  logic [127:0] sram_rdata;
  logic         illegal_op;

  rc_sram_ctrl_if #(.Cfg(CFG)) bus ();

  rc_sram_ctrl #(.Cfg(CFG)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .wbuf_rd_valid   (wbuf_rd_valid),
    .wbuf_rd_id      (wbuf_rd_id),
    .wbuf_rd_data    (wbuf_rd_data),
    .wbuf_rd_be      (wbuf_rd_be),
    .wbuf_free_valid (wbuf_free_valid),
    .wbuf_free_id    (wbuf_free_id),
    .sram_ce         (sram_ce),
    .sram_we         (sram_we),
    .sram_addr       (sram_addr),
    .sram_wdata      (sram_wdata),
    .sram_be         (sram_be),
    .sram_rdata      (sram_rdata),
    .illegal_op      (illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   chan;
    logic [4:0]   rob;
    logic [2:0]   op;
    logic [127:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    tests++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %h required %h", nm, act, req);
    end
  endtask

  task automatic drive_req(input logic [2:0] ch, input logic [4:0] rob, input logic [2:0] op,
                           input logic [5:0] set, input logic [1:0] way, input logic [2:0] wb,
                           input logic [127:0] refill);
    bus.d_rc_valid           = 1'b1;
    bus.d_rc_channel_1hot_id = ch;
    bus.d_rc_rob_id          = rob;
    bus.d_rc_op              = op;
    bus.d_rc_set             = set;
    bus.d_rc_way             = way;
    bus.d_rc_wbuf_id         = wb;
    bus.d_rc_refill_data     = refill;
  endtask

  // Scoreboard monitor: every response handshake must match the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (bus.resp_valid && bus.resp_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          errors++;
          $display("FAIL resp_unexpected: actual rob %0d op %0d required no response",
                   bus.resp_rob_id, bus.resp_op);
        end else begin
          e = exp_q.pop_front();
          chk("resp_chan", 128'(bus.resp_channel_1hot_id), 128'(e.chan));
          chk("resp_rob", 128'(bus.resp_rob_id), 128'(e.rob));
          chk("resp_op", 128'(bus.resp_op), 128'(e.op));
          chk("resp_data", bus.resp_data, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.d_rc_valid = 1'b0;
    bus.d_rc_channel_1hot_id = '0;
    bus.d_rc_rob_id = '0;
    bus.d_rc_op = '0;
    bus.d_rc_set = '0;
    bus.d_rc_way = '0;
    bus.d_rc_wbuf_id = '0;
    bus.d_rc_refill_data = '0;
    bus.resp_ready = 1'b1;
    wbuf_rd_data = '0;
    wbuf_rd_be = '0;
    sram_rdata = '0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 128'(bus.d_rc_ready), 128'(1));
    chk("rst_resp_valid", 128'(bus.resp_valid), 128'(0));
    chk("rst_sram_ce", 128'(sram_ce), 128'(0));
    chk("rst_wbuf_rd", 128'(wbuf_rd_valid), 128'(0));
    chk("rst_wbuf_free", 128'(wbuf_free_valid), 128'(0));
    chk("rst_illegal", 128'(illegal_op), 128'(0));
    rst = 1'b0;

    // LOAD set=3 way=1
    @(negedge clk);
    drive_req(3'b010, 5'd7, CACHE_OP_LOAD, 6'd3, 2'd1, 3'd0, '0);
    exp_q.push_back('{3'b010, 5'd7, CACHE_OP_LOAD, {16{8'hA5}}});
    @(negedge clk);
    bus.d_rc_valid = 1'b0;
    #1;
    chk("ld_ce", 128'(sram_ce), 128'(1));
    chk("ld_we", 128'(sram_we), 128'(0));
    chk("ld_addr", 128'(sram_addr), 128'({2'd1, 6'd3}));
    @(negedge clk);
    sram_rdata = {16{8'hA5}};
    #1;
    chk("ld_t2_resp_valid", 128'(bus.resp_valid), 128'(0));
    @(negedge clk);
    sram_rdata = '0;
    #1;
    chk("ld_t3_resp_valid", 128'(bus.resp_valid), 128'(1));
    chk("ld_t3_ce", 128'(sram_ce), 128'(0));
    @(negedge clk);
    #1;
    chk("ld_done_ready", 128'(bus.d_rc_ready), 128'(1));

    // STORE wbuf_id=5, be=000F
    @(negedge clk);
    drive_req(3'b001, 5'd9, CACHE_OP_STORE, 6'd2, 2'd0, 3'd5, '0);
    exp_q.push_back('{3'b001, 5'd9, CACHE_OP_STORE, 128'd0});
    @(negedge clk);
    bus.d_rc_valid = 1'b0;
    #1;
    chk("st_wbuf_rd_valid", 128'(wbuf_rd_valid), 128'(1));
    chk("st_wbuf_rd_id", 128'(wbuf_rd_id), 128'(5));
    chk("st_t1_ce", 128'(sram_ce), 128'(0));
    @(negedge clk);
    wbuf_rd_data = {16{8'h3C}};
    wbuf_rd_be = 16'h000F;
    #1;
    chk("st_ce", 128'(sram_ce), 128'(1));
    chk("st_we", 128'(sram_we), 128'(1));
    chk("st_addr", 128'(sram_addr), 128'({2'd0, 6'd2}));
    chk("st_wdata", sram_wdata, {16{8'h3C}});
    chk("st_be", 128'(sram_be), 128'(16'h000F));
    chk("st_free_valid", 128'(wbuf_free_valid), 128'(1));
    chk("st_free_id", 128'(wbuf_free_id), 128'(5));
    @(negedge clk);
    wbuf_rd_data = '0;
    wbuf_rd_be = '0;
    #1;
    chk("st_t3_resp_valid", 128'(bus.resp_valid), 128'(1));
    chk("st_t3_free_valid", 128'(wbuf_free_valid), 128'(0));
    @(negedge clk);

    // STORE_REFILL: wbuf bytes 0 and 15 over a 0x11 refill line
    @(negedge clk);
    drive_req(3'b100, 5'd10, CACHE_OP_STORE_REFILL, 6'd8, 2'd3, 3'd2, {16{8'h11}});
    exp_q.push_back('{3'b100, 5'd10, CACHE_OP_STORE_REFILL, 128'd0});
    @(negedge clk);
    bus.d_rc_valid = 1'b0;
    #1;
    chk("sr_wbuf_rd_id", 128'(wbuf_rd_id), 128'(2));
    @(negedge clk);
    wbuf_rd_data = {16{8'h22}};
    wbuf_rd_be = 16'h8001;
    #1;
    chk("sr_we", 128'(sram_we), 128'(1));
    chk("sr_wdata", sram_wdata, {8'h22, {14{8'h11}}, 8'h22});
    chk("sr_be", 128'(sram_be), 128'(16'hFFFF));
    chk("sr_free_id", 128'(wbuf_free_id), 128'(2));
    @(negedge clk);
    wbuf_rd_data = '0;
    wbuf_rd_be = '0;
    #1;
    chk("sr_t3_resp_valid", 128'(bus.resp_valid), 128'(1));
    @(negedge clk);

    // LOAD_REFILL: full-line write, no read
    @(negedge clk);
    drive_req(3'b010, 5'd11, CACHE_OP_LOAD_REFILL, 6'd1, 2'd2, 3'd0, {8{16'hDEAD}});
    exp_q.push_back('{3'b010, 5'd11, CACHE_OP_LOAD_REFILL, {8{16'hDEAD}}});
    @(negedge clk);
    bus.d_rc_valid = 1'b0;
    #1;
    chk("lr_ce", 128'(sram_ce), 128'(1));
    chk("lr_we", 128'(sram_we), 128'(1));
    chk("lr_be", 128'(sram_be), 128'(16'hFFFF));
    chk("lr_wdata", sram_wdata, {8{16'hDEAD}});
    chk("lr_addr", 128'(sram_addr), 128'({2'd2, 6'd1}));
    chk("lr_free_valid", 128'(wbuf_free_valid), 128'(0));
    @(negedge clk);
    #1;
    chk("lr_t2_resp_valid", 128'(bus.resp_valid), 128'(1));
    chk("lr_t2_ce", 128'(sram_ce), 128'(0));
    @(negedge clk);

    // Backpressure: resp_ready low for 10 cycles with a new request waiting
    @(negedge clk);
    drive_req(3'b001, 5'd12, CACHE_OP_LOAD, 6'd4, 2'd0, 3'd0, '0);
    exp_q.push_back('{3'b001, 5'd12, CACHE_OP_LOAD, {4{32'h12345678}}});
    @(negedge clk);
    bus.d_rc_valid = 1'b0;
    @(negedge clk);
    sram_rdata = {4{32'h12345678}};
    bus.resp_ready = 1'b0;
    @(negedge clk);
    sram_rdata = '0;
    drive_req(3'b100, 5'd13, CACHE_OP_LOAD, 6'd5, 2'd1, 3'd0, '0);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("stall_resp_valid", 128'(bus.resp_valid), 128'(1));
      chk("stall_ready", 128'(bus.d_rc_ready), 128'(0));
      chk("stall_data", bus.resp_data, {4{32'h12345678}});
      chk("stall_rob", 128'(bus.resp_rob_id), 128'(12));
      @(negedge clk);
    end
    bus.resp_ready = 1'b1;
    #1;
    chk("stall_release_valid", 128'(bus.resp_valid), 128'(1));
    @(negedge clk);
    exp_q.push_back('{3'b100, 5'd13, CACHE_OP_LOAD, {16{8'h5A}}});
    #1;
    chk("post_hs_ready", 128'(bus.d_rc_ready), 128'(1));
    chk("post_hs_ce", 128'(sram_ce), 128'(0));
    @(negedge clk);
    bus.d_rc_valid = 1'b0;
    #1;
    chk("post_hs_accept_ce", 128'(sram_ce), 128'(1));
    chk("post_hs_addr", 128'(sram_addr), 128'({2'd1, 6'd5}));
    @(negedge clk);
    sram_rdata = {16{8'h5A}};
    @(negedge clk);
    sram_rdata = '0;
    #1;
    chk("post_hs_resp_valid", 128'(bus.resp_valid), 128'(1));
    @(negedge clk);

    // Reset asserted during SRAM_WR of a store: dropped, not freed, not answered
    @(negedge clk);
    drive_req(3'b001, 5'd14, CACHE_OP_STORE, 6'd6, 2'd0, 3'd3, '0);
    @(negedge clk);
    bus.d_rc_valid = 1'b0;
    @(negedge clk);
    wbuf_rd_data = {16{8'h77}};
    wbuf_rd_be = 16'hFFFF;
    #1;
    chk("rstwr_we_before", 128'(sram_we), 128'(1));
    rst = 1'b1;
    #1;
    chk("rstwr_ce", 128'(sram_ce), 128'(0));
    chk("rstwr_we", 128'(sram_we), 128'(0));
    chk("rstwr_wdata", sram_wdata, 128'd0);
    chk("rstwr_free", 128'(wbuf_free_valid), 128'(0));
    chk("rstwr_ready", 128'(bus.d_rc_ready), 128'(1));
    chk("rstwr_resp_valid", 128'(bus.resp_valid), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    wbuf_rd_data = '0;
    wbuf_rd_be = '0;
    @(negedge clk);
    #1;
    chk("rstwr_after_resp", 128'(bus.resp_valid), 128'(0));
    chk("rstwr_after_illegal", 128'(illegal_op), 128'(0));

    // Unsupported op
    @(negedge clk);
    drive_req(3'b010, 5'd15, 3'b111, 6'd9, 2'd1, 3'd1, '0);
    @(negedge clk);
    bus.d_rc_valid = 1'b0;
    #1;
    chk("bad_illegal", 128'(illegal_op), 128'(1));
    chk("bad_ready", 128'(bus.d_rc_ready), 128'(1));
    for (int i = 0; i < 3; i++) begin
      chk("bad_ce", 128'(sram_ce), 128'(0));
      chk("bad_wbuf_rd", 128'(wbuf_rd_valid), 128'(0));
      chk("bad_resp_valid", 128'(bus.resp_valid), 128'(0));
      @(negedge clk);
      #1;
    end
    chk("bad_illegal_sticky", 128'(illegal_op), 128'(1));

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
